// File: rtl/cpu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pipe_pkg
// Brief    : Shared pipeline constants and slot record for stage buffers.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pipe_pkg;

    localparam int unsigned c_data_w = 32;
    localparam int unsigned c_pc_w   = 32;
    localparam logic [c_data_w-1:0] c_nop_word = 32'h0000_0000;

    typedef struct packed {
        logic                valid;
        logic [c_data_w-1:0] instr;
        logic [c_pc_w-1:0]   pcplus;
        logic                irq;
    } slot_t;

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module   : pipe_slot
// Brief    : One pipeline slot register with load, clear and bubble controls.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_slot
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned       DATA_W   = c_data_w,
    parameter int unsigned       PC_W     = c_pc_w,
    parameter logic [DATA_W-1:0] NOP_WORD = c_nop_word
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic              bubble,
    input  logic [DATA_W-1:0] d_instr,
    input  logic [PC_W-1:0]   d_pcplus,
    input  logic              d_irq,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_instr,
    output logic [PC_W-1:0]   q_pcplus,
    output logic              q_irq
);

    logic              r_valid;
    logic [DATA_W-1:0] r_instr;
    logic [PC_W-1:0]   r_pcplus;
    logic              r_irq;

    // Bubble and clear both keep pcplus so decode still sees a sane return address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_instr  <= NOP_WORD;
            r_pcplus <= '0;
            r_irq    <= 1'b0;
        end else if (bubble) begin
            r_valid  <= 1'b1;
            r_instr  <= NOP_WORD;
            r_irq    <= 1'b0;
        end else if (clear) begin
            r_valid  <= 1'b0;
            r_instr  <= NOP_WORD;
            r_irq    <= 1'b0;
        end else if (load) begin
            r_valid  <= 1'b1;
            r_instr  <= d_instr;
            r_pcplus <= d_pcplus;
            r_irq    <= d_irq;
        end
    end

    assign q_valid  = r_valid;
    assign q_instr  = r_instr;
    assign q_pcplus = r_pcplus;
    assign q_irq    = r_irq;

endmodule
`default_nettype wire

// File: rtl/ifid_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : ifid_stage_buf
// Brief    : IF/ID ready/valid stage with skid slot, flush bubble, sticky irq.
// Revision : 1.0 - initial release
// ============================================================================
module ifid_stage_buf
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned       DATA_W          = c_data_w,
    parameter int unsigned       PC_W            = c_pc_w,
    parameter logic [DATA_W-1:0] NOP_WORD        = c_nop_word,
    parameter bit                BUBBLE_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [PC_W-1:0]   in_pcplus,
    input  logic              in_irq,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pcplus,
    output logic              out_irq,
    output logic              irq_pending
);

    logic              w_m_valid;
    logic [DATA_W-1:0] w_m_instr;
    logic [PC_W-1:0]   w_m_pcplus;
    logic              w_m_irq;
    logic              w_s_valid;
    logic [DATA_W-1:0] w_s_instr;
    logic [PC_W-1:0]   w_s_pcplus;
    logic              w_s_irq;

    logic              w_accept;
    logic              w_issue;
    logic              w_main_take;
    logic              w_in_irq_eff;
    logic              w_drop_irq;
    logic              w_main_load;
    logic              w_main_clear;
    logic              w_main_bubble;
    logic [DATA_W-1:0] w_main_instr;
    logic [PC_W-1:0]   w_main_pcplus;
    logic              w_main_irq;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic              r_pend;

    assign in_ready     = ~w_s_valid & ~reset;
    assign w_accept     = in_valid & in_ready;
    assign w_issue      = w_m_valid & out_ready;
    assign w_main_take  = ~w_m_valid | w_issue;
    assign w_in_irq_eff = in_irq | r_pend;

    // Skid entry is always older than the input, so it wins the main slot.
    assign w_main_instr  = w_s_valid ? w_s_instr  : in_instr;
    assign w_main_pcplus = w_s_valid ? w_s_pcplus : in_pcplus;
    assign w_main_irq    = w_s_valid ? w_s_irq    : w_in_irq_eff;

    assign w_main_bubble = flush & BUBBLE_ON_FLUSH;
    assign w_main_clear  = (flush & ~BUBBLE_ON_FLUSH)
                         | (~flush & w_main_take & ~w_s_valid & ~w_accept);
    assign w_main_load   = ~flush & w_main_take & (w_s_valid | w_accept);

    assign w_skid_clear  = flush | (w_main_take & w_s_valid);
    assign w_skid_load   = ~flush & w_accept & w_m_valid & ~w_issue;

    assign w_drop_irq    = (w_m_valid & ~w_issue & w_m_irq) | (w_s_valid & w_s_irq);

    pipe_slot #(
        .DATA_W   (DATA_W),
        .PC_W     (PC_W),
        .NOP_WORD (NOP_WORD)
    ) u_main (
        .clk      (clk),
        .reset    (reset),
        .load     (w_main_load),
        .clear    (w_main_clear),
        .bubble   (w_main_bubble),
        .d_instr  (w_main_instr),
        .d_pcplus (w_main_pcplus),
        .d_irq    (w_main_irq),
        .q_valid  (w_m_valid),
        .q_instr  (w_m_instr),
        .q_pcplus (w_m_pcplus),
        .q_irq    (w_m_irq)
    );

    pipe_slot #(
        .DATA_W   (DATA_W),
        .PC_W     (PC_W),
        .NOP_WORD (NOP_WORD)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (w_skid_load),
        .clear    (w_skid_clear),
        .bubble   (1'b0),
        .d_instr  (in_instr),
        .d_pcplus (in_pcplus),
        .d_irq    (w_in_irq_eff),
        .q_valid  (w_s_valid),
        .q_instr  (w_s_instr),
        .q_pcplus (w_s_pcplus),
        .q_irq    (w_s_irq)
    );

    // While reset is held, in_irq is latched so a request at reset release is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= in_irq;
        end else if (flush) begin
            r_pend <= r_pend | w_drop_irq | in_irq;
        end else if (w_accept) begin
            r_pend <= 1'b0;
        end else if (in_irq & ~in_valid) begin
            r_pend <= 1'b1;
        end
    end

    assign out_valid   = w_m_valid;
    assign out_instr   = w_m_instr;
    assign out_pcplus  = w_m_pcplus;
    assign out_irq     = w_m_irq;
    assign irq_pending = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_ifid_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifid_stage_buf
// Brief    : Directed vector bench for the IF/ID stage buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifid_stage_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pcplus;
    logic        in_irq;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pcplus;
    logic        out_irq;
    logic        irq_pending;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] instr;
        logic        irq;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_irq;
        logic        e_pend;
        logic        e_irdy;
    } vec_t;

    vec_t vecs[28];

    ifid_stage_buf dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pcplus   (in_pcplus),
        .in_irq      (in_irq),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pcplus  (out_pcplus),
        .out_irq     (out_irq),
        .irq_pending (irq_pending)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] instr,
                                input logic irq, input logic ordy, input logic e_ov,
                                input logic [31:0] e_instr, input logic [31:0] e_pc,
                                input logic e_irq, input logic e_pend, input logic e_irdy);
        vec_t v;
        v.fl = fl; v.iv = iv; v.instr = instr; v.irq = irq; v.ordy = ordy;
        v.e_ov = e_ov; v.e_instr = e_instr; v.e_pc = e_pc;
        v.e_irq = e_irq; v.e_pend = e_pend; v.e_irdy = e_irdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        // streaming A..D
        vecs[0]  = mk(0, 1, 32'h11, 0, 1,  1, 32'h11, 32'h1011, 0, 0, 1);
        vecs[1]  = mk(0, 1, 32'h22, 0, 1,  1, 32'h22, 32'h1022, 0, 0, 1);
        vecs[2]  = mk(0, 1, 32'h33, 0, 1,  1, 32'h33, 32'h1033, 0, 0, 1);
        vecs[3]  = mk(0, 1, 32'h44, 0, 1,  1, 32'h44, 32'h1044, 0, 0, 1);
        vecs[4]  = mk(0, 0, 32'h00, 0, 1,  0, 32'h00, 32'h1044, 0, 0, 1);
        // stall: A held, B to skid, C held off, then A B C in order
        vecs[5]  = mk(0, 1, 32'h11, 0, 0,  1, 32'h11, 32'h1011, 0, 0, 1);
        vecs[6]  = mk(0, 1, 32'h22, 0, 0,  1, 32'h11, 32'h1011, 0, 0, 0);
        vecs[7]  = mk(0, 1, 32'h33, 0, 0,  1, 32'h11, 32'h1011, 0, 0, 0);
        vecs[8]  = mk(0, 1, 32'h33, 0, 0,  1, 32'h11, 32'h1011, 0, 0, 0);
        vecs[9]  = mk(0, 1, 32'h33, 0, 1,  1, 32'h22, 32'h1022, 0, 0, 1);
        vecs[10] = mk(0, 1, 32'h33, 0, 1,  1, 32'h33, 32'h1033, 0, 0, 1);
        vecs[11] = mk(0, 0, 32'h00, 0, 1,  0, 32'h00, 32'h1033, 0, 0, 1);
        // flush with A in main, B (irq) in skid -> bubble, pending, then E
        vecs[12] = mk(0, 1, 32'h11, 0, 0,  1, 32'h11, 32'h1011, 0, 0, 1);
        vecs[13] = mk(0, 1, 32'h22, 1, 0,  1, 32'h11, 32'h1011, 0, 0, 0);
        vecs[14] = mk(1, 0, 32'h00, 0, 0,  1, 32'h00, 32'h1011, 0, 1, 1);
        vecs[15] = mk(0, 1, 32'h55, 0, 1,  1, 32'h55, 32'h1055, 1, 0, 1);
        vecs[16] = mk(0, 0, 32'h00, 0, 1,  0, 32'h00, 32'h1055, 0, 0, 1);
        // flush while A(irq) issues and B(irq) is accepted
        vecs[17] = mk(0, 1, 32'h11, 1, 0,  1, 32'h11, 32'h1011, 1, 0, 1);
        vecs[18] = mk(1, 1, 32'h22, 1, 1,  1, 32'h00, 32'h1011, 0, 1, 1);
        vecs[19] = mk(0, 0, 32'h00, 0, 1,  0, 32'h00, 32'h1011, 0, 1, 1);
        vecs[20] = mk(0, 1, 32'h66, 0, 1,  1, 32'h66, 32'h1066, 1, 0, 1);
        // sticky capture with in_valid low
        vecs[21] = mk(0, 0, 32'h00, 1, 1,  0, 32'h00, 32'h1066, 0, 1, 1);
        vecs[22] = mk(0, 0, 32'h00, 0, 1,  0, 32'h00, 32'h1066, 0, 1, 1);
        vecs[23] = mk(0, 1, 32'h77, 0, 1,  1, 32'h77, 32'h1077, 1, 0, 1);
        // flush with issue and accept, no irq on the dropped entry
        vecs[24] = mk(1, 1, 32'h88, 0, 1,  1, 32'h00, 32'h1077, 0, 0, 1);
        vecs[25] = mk(0, 0, 32'h00, 0, 1,  0, 32'h00, 32'h1077, 0, 0, 1);
        // fill both slots ahead of the reset-during-stall sequence
        vecs[26] = mk(0, 1, 32'h99, 0, 0,  1, 32'h99, 32'h1099, 0, 0, 1);
        vecs[27] = mk(0, 1, 32'hAA, 0, 0,  1, 32'h99, 32'h1099, 0, 0, 0);

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
        in_pcplus = '0; in_irq = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid",  {31'b0, out_valid},   32'h0);
        chk("rst_out_instr",  out_instr,            32'h0);
        chk("rst_out_pcplus", out_pcplus,           32'h0);
        chk("rst_out_irq",    {31'b0, out_irq},     32'h0);
        chk("rst_irq_pend",   {31'b0, irq_pending}, 32'h0);
        chk("rst_in_ready",   {31'b0, in_ready},    32'h0);
        reset = 1'b0;
        #1;
        chk("rel_in_ready",   {31'b0, in_ready},    32'h1);

        for (int i = 0; i < 28; i++) begin
            flush     = vecs[i].fl;
            in_valid  = vecs[i].iv;
            in_instr  = vecs[i].instr;
            in_pcplus = 32'h1000 + vecs[i].instr;
            in_irq    = vecs[i].irq;
            out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i),  {31'b0, out_valid},   {31'b0, vecs[i].e_ov});
            chk($sformatf("v%0d_out_instr", i),  out_instr,            vecs[i].e_instr);
            chk($sformatf("v%0d_out_pcplus", i), out_pcplus,           vecs[i].e_pc);
            chk($sformatf("v%0d_out_irq", i),    {31'b0, out_irq},     {31'b0, vecs[i].e_irq});
            chk($sformatf("v%0d_irq_pend", i),   {31'b0, irq_pending}, {31'b0, vecs[i].e_pend});
            chk($sformatf("v%0d_in_ready", i),   {31'b0, in_ready},    {31'b0, vecs[i].e_irdy});
        end

        // reset during a stall with both slots full
        flush = 1'b0; in_valid = 1'b0; in_irq = 1'b0; out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_out_valid",  {31'b0, out_valid},   32'h0);
        chk("post_rst_out_instr",  out_instr,            32'h0);
        chk("post_rst_out_pcplus", out_pcplus,           32'h0);
        chk("post_rst_in_ready",   {31'b0, in_ready},    32'h1);
        chk("post_rst_irq_pend",   {31'b0, irq_pending}, 32'h0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_skid_gone",  {31'b0, out_valid},   32'h0);
        chk("post_rst_ready_hold", {31'b0, in_ready},    32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifid_stage_buf.md
# ifid_stage_buf

Parametrised fetch/decode pipeline stage buffer that replaces the bare IF/ID register with a ready/valid stage. It holds the fetched instruction, its PC+4 and an interrupt flag, and adds a one-entry skid slot so backpressure from decode reaches fetch through a registered ready. It supports flush with a configurable bubble and a sticky interrupt that is never lost across flushes or stalls. It sits between the fetch unit and the decode stage.

## Interface
- DATA_W, 32, instruction width
- PC_W, 32, PC+4 width
- NOP_WORD, 32'h0, instruction value presented when the stage is empty or flushed
- BUBBLE_ON_FLUSH, 1, 1: flush leaves a valid NOP bubble; 0: flush leaves the stage empty

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all held and incoming entries (branch/jump/exception redirect)
- in_valid  in  1  fetch presents an entry
- in_ready  out  1  stage can accept; registered
- in_instr  in  DATA_W  fetched instruction
- in_pcplus  in  PC_W  PC+4 of the fetched instruction
- in_irq  in  1  interrupt request sampled with the entry
- out_valid  out  1  entry presented to decode
- out_ready  in  1  decode accepts; low means hazard stall
- out_instr  out  DATA_W  instruction to decode
- out_pcplus  out  PC_W  PC+4 to decode
- out_irq  out  1  interrupt attached to the presented entry
- irq_pending  out  1  sticky interrupt not yet attached to an entry

## Operation
- Storage: main slot (drives the out_* ports) and skid slot. Each slot holds valid, instr, pcplus and irq.
- Handshakes: accept = in_valid & in_ready; issue = out_valid & out_ready.
- in_ready = ~skid.valid & ~reset.
- Main-slot load: the main slot loads when it is empty or issuing. It takes the skid slot if the skid slot is valid, otherwise the input if accepting. Otherwise it goes empty.
- Skid-slot load: the skid slot loads the input when accept occurs while the main slot is valid and not issuing. It clears when its entry moves to the main slot.
- Ordering: strict FIFO. The skid entry always precedes the input.
- IRQ attach: an accepted entry stores irq = in_irq | irq_pending. irq_pending clears on that accept.
- Sticky capture: in_irq=1 with in_valid=0, or during reset release, sets irq_pending.
- Flush, applied at the clock edge and overriding all loads:
  - An issue in the same cycle completes and its irq is delivered.
  - All other held entries are discarded, including an input accepted that cycle.
  - The OR of the discarded entries' irq bits and in_irq sets irq_pending.
- After flush with BUBBLE_ON_FLUSH=1: the main slot holds valid=1, instr=NOP_WORD, irq=0, pcplus unchanged. The bubble issues like any entry.
- After flush with BUBBLE_ON_FLUSH=0: the main slot is empty.
- Empty main slot: out_instr=NOP_WORD, out_irq=0, out_pcplus holds its last value.
- Reset values: out_valid=0, out_instr=NOP_WORD, out_pcplus=0, out_irq=0, irq_pending=0, skid empty. in_ready is 0 while reset is high and 1 on the first cycle after.
- Reset overrides flush. Reset mid-stall discards both slots.

## Timing
- Latency: an entry accepted at edge N is on out_* after edge N when the stage was empty.
- Throughput: 1 entry/cycle while out_ready=1.
- in_ready has no combinational path from out_ready or flush. It falls one cycle after the skid slot fills.
- A stall of k cycles with in_valid held accepts at most one extra entry, into the skid slot.
- flush acts in the same cycle it is asserted. No entry presented before the edge survives except one issuing that cycle.

## Structure
- Shared package `cpu_pipe_pkg`: NOP_WORD default, the slot record typedef (valid, instr, pcplus, irq), and the width constants used by the other pipeline registers.
- Sub-module `pipe_slot`: one parametrised slot register with load/clear/bubble controls. It is instantiated twice, as the main slot and the skid slot.
- The top level contains only the steering logic and the irq_pending latch.

## Test plan
- Streaming: entries A..D (instr 32'h11..32'h44) with out_ready=1. Required: each appears exactly one cycle after accept, with in_ready=1 throughout.
- Stall: out_ready=0 for 3 cycles while fetching A, B, C. Required: A is held, B goes to the skid slot, in_ready drops and C is held off. On release the output order is A, B, C with no loss or duplicate.
- Flush with BUBBLE_ON_FLUSH=1 while A is in main and B is in skid. Required: the next cycle gives out_valid=1, out_instr=32'h0, out_irq=0. The stage then resumes with the new entry E.
- IRQ across flush: in_irq=1 on B, then flush before B issues. Required: irq_pending=1. The next accepted entry E issues with out_irq=1 and irq_pending clears.
- Flush in the same cycle as issue of A (irq=1) and accept of B. Required: A is delivered with out_irq=1, B is discarded, and irq_pending reflects B's in_irq.
- Reset during a stall with both slots full. Required: the next cycle has out_valid=0, out_instr=NOP_WORD, out_pcplus=0, in_ready=1, irq_pending=0.
